// File: rtl/spi_read_fifo.sv
// -----------------------------------------------------------------------------
// spi_read_fifo
//
// Collects the bytes returned by a multi-register SPI chip read into a
// first-word-fall-through FIFO that the bus side drains with pop/dout.
// A small FSM (IDLE / COLLECT / DONE) counts received against expected bytes
// and raises sticky read_done, overflow and timeout flags.
//
// Build option:
//   SPI_RDFIFO_ADDR_TAG_EN  defined   -> 16-bit entries, dout = {reg_addr, data}
//                           undefined -> 8-bit entries, dout = data; no address
//                                        counter is built
//
// Parameters:
//   DEPTH           FIFO entries, power of two, >= 2
//   TIMEOUT_CYCLES  max clk cycles between bytes while collecting (0 = off)
//
// Ports:
//   clk, rstn                 IP clock, asynchronous active-low reset
//   cmd_start                 1-cycle pulse: a read command was issued
//   cmd_num_regs              bytes expected (sampled on cmd_start)
//   cmd_start_addr            first register address (sampled on cmd_start)
//   rd_byte, rd_byte_valid    byte and strobe from the SPI driver
//   flush                     empty the FIFO and clear overflow
//   pop                       consume the head entry
//   dout                      head entry (valid whenever empty == 0)
//   empty, full, level        FIFO status
//   busy                      collecting bytes of a command
//   read_done, overflow,
//   timeout                   sticky status flags
// -----------------------------------------------------------------------------
module spi_read_fifo #(
    parameter int DEPTH          = 256,
    parameter int TIMEOUT_CYCLES = 65535,
`ifdef SPI_RDFIFO_ADDR_TAG_EN
    localparam int DW            = 16
`else
    localparam int DW            = 8
`endif
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_start,
    input  logic [7:0]               cmd_num_regs,
    input  logic [7:0]               cmd_start_addr,
    input  logic [7:0]               rd_byte,
    input  logic                     rd_byte_valid,
    input  logic                     flush,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     read_done,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The timer counts idle cycles 0..TIMEOUT_CYCLES-1; reaching the last
    // value with no strobe is the TIMEOUT_CYCLES-th idle cycle.
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    // ---------------------------------------------------------------- FSM
    state_e          state_q, state_d;
    logic [7:0]      exp_q, exp_d;
    logic [7:0]      rcv_q, rcv_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            read_done_q, read_done_d;
    logic            timeout_q, timeout_d;
    logic            push_req;
    logic [7:0]      rcv_inc;
    logic [DW-1:0]   push_data;

    assign rcv_inc = rcv_q + 8'd1;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        rcv_d       = rcv_q;
        timer_d     = timer_q;
        read_done_d = read_done_q;
        timeout_d   = timeout_q;
        push_req    = 1'b0;

        if (cmd_start) begin
            // A new command always wins, aborting any read in flight; a strobe
            // in this same cycle belongs to nobody and is dropped.
            exp_d     = cmd_num_regs;
            rcv_d     = 8'd0;
            timer_d   = '0;
            timeout_d = 1'b0;
            if (cmd_num_regs == 8'd0) begin
                state_d     = S_DONE;
                read_done_d = 1'b1;
            end else begin
                state_d     = S_COLLECT;
                read_done_d = 1'b0;
            end
        end else if (state_q == S_COLLECT) begin
            if (rd_byte_valid) begin
                push_req = 1'b1;
                rcv_d    = rcv_inc;
                timer_d  = '0;
                if (rcv_inc == exp_q) begin
                    state_d     = S_DONE;
                    read_done_d = 1'b1;
                end
            end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
                state_d   = S_IDLE;
                timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            exp_q       <= 8'd0;
            rcv_q       <= 8'd0;
            timer_q     <= '0;
            read_done_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            rcv_q       <= rcv_d;
            timer_q     <= timer_d;
            read_done_q <= read_done_d;
            timeout_q   <= timeout_d;
        end
    end

    // ---------------------------------------------------- address tagging
`ifdef SPI_RDFIFO_ADDR_TAG_EN
    logic [7:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (cmd_start) begin
            addr_d = cmd_start_addr;
        end else if (push_req) begin
            // Advances on every accepted strobe, even if the FIFO drops it.
            addr_d = addr_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q <= 8'd0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign push_data = {addr_q, rd_byte};
`else
    logic unused_start_addr;
    assign unused_start_addr = ^cmd_start_addr;
    assign push_data         = rd_byte;
`endif

    // --------------------------------------------------------------- FIFO
    logic [DW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           overflow_q, overflow_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic           do_pop, do_push, wr_en;

    assign do_pop  = pop && (level_q != '0);
    // When full, a simultaneous pop frees the slot this push lands in.
    assign do_push = push_req && ((level_q != LEVEL_FULL) || do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        dout_d     = dout_q;
        wr_en      = 1'b0;

        if (flush) begin
            // Flush beats push and pop; dout keeps its last value.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else if (push_req) begin
                overflow_d = 1'b1;
            end
            level_d = level_q + LW'(do_push) - LW'(do_pop);
            // dout is a registered copy of the next head. The new head is the
            // byte being written this cycle when it lands in the head slot
            // (empty FIFO, or the last entry popped while pushing).
            if (level_d != '0) begin
                dout_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
            end
        end
    end

    // NOTE: the storage array has no reset; only pointers, level and dout do,
    // which is enough to make every stale entry unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            dout_q     <= dout_d;
        end
    end

    // ------------------------------------------------------------ outputs
    assign dout      = dout_q;
    assign empty     = (level_q == '0);
    assign full      = (level_q == LEVEL_FULL);
    assign level     = level_q;
    assign busy      = (state_q == S_COLLECT);
    assign read_done = read_done_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_spi_read_fifo.sv
// -----------------------------------------------------------------------------
// tb_spi_read_fifo
//
// Directed bench for spi_read_fifo (DEPTH=4, TIMEOUT_CYCLES=10). A queue-based
// model tracks what the FIFO must hold and which flags must be set; a compare
// process checks every output against it on each falling clock edge. Literal
// expectations in the directed sequence pin the model itself. Works with the
// SPI_RDFIFO_ADDR_TAG_EN option either defined or not.
// -----------------------------------------------------------------------------
module tb_spi_read_fifo;

    localparam int DEPTH = 4;
    localparam int TMO   = 10;
`ifdef SPI_RDFIFO_ADDR_TAG_EN
    localparam int DW    = 16;
`else
    localparam int DW    = 8;
`endif
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_start = 1'b0;
    logic [7:0]    cmd_num_regs = 8'd0;
    logic [7:0]    cmd_start_addr = 8'd0;
    logic [7:0]    rd_byte = 8'd0;
    logic          rd_byte_valid = 1'b0;
    logic          flush = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] dout;
    logic          empty, full, busy, read_done, overflow, timeout;
    logic [LW-1:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    spi_read_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cmd_start      (cmd_start),
        .cmd_num_regs   (cmd_num_regs),
        .cmd_start_addr (cmd_start_addr),
        .rd_byte        (rd_byte),
        .rd_byte_valid  (rd_byte_valid),
        .flush          (flush),
        .pop            (pop),
        .dout           (dout),
        .empty          (empty),
        .full           (full),
        .level          (level),
        .busy           (busy),
        .read_done      (read_done),
        .overflow       (overflow),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ent(input logic [7:0] a, input logic [7:0] d);
`ifdef SPI_RDFIFO_ADDR_TAG_EN
        return {a, d};
`else
        return DW'(d) | DW'(a & 8'h00);
`endif
    endfunction

    // ------------------------------------------------------------- model
    logic          m_collect = 1'b0;
    int            m_exp = 0;
    int            m_rcv = 0;
    int            m_idle = 0;
    logic [7:0]    m_addr = 8'd0;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_head = '0;
    logic          m_done = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_to = 1'b0;
    logic          m_push;
    logic [DW-1:0] m_ent;
    int            m_n0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_collect = 1'b0; m_exp = 0; m_rcv = 0; m_idle = 0; m_addr = 8'd0;
            m_q.delete(); m_head = '0; m_done = 1'b0; m_ovf = 1'b0; m_to = 1'b0;
        end else begin
            m_push = 1'b0;
            m_ent  = '0;
            if (cmd_start) begin
                m_exp = cmd_num_regs; m_rcv = 0; m_idle = 0; m_addr = cmd_start_addr;
                m_to = 1'b0;
                m_done = (cmd_num_regs == 8'd0);
                m_collect = (cmd_num_regs != 8'd0);
            end else if (m_collect) begin
                if (rd_byte_valid) begin
                    m_push = 1'b1;
                    m_ent  = ent(m_addr, rd_byte);
                    m_addr = m_addr + 8'd1;
                    m_rcv++;
                    m_idle = 0;
                    if (m_rcv == m_exp) begin
                        m_collect = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_collect = 1'b0;
                        m_to = 1'b1;
                    end
                end
            end
            m_n0 = m_q.size();
            if (flush) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (pop && m_n0 > 0) void'(m_q.pop_front());
                if (m_push) begin
                    if (m_n0 < DEPTH || pop) m_q.push_back(m_ent);
                    else m_ovf = 1'b1;
                end
            end
            if (m_q.size() > 0) m_head = m_q[0];
        end
    end

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        check("dout",      32'(dout),      32'(m_head));
        check("empty",     32'(empty),     32'(m_q.size() == 0));
        check("full",      32'(full),      32'(m_q.size() == DEPTH));
        check("level",     32'(level),     32'(m_q.size()));
        check("busy",      32'(busy),      32'(m_collect));
        check("read_done", 32'(read_done), 32'(m_done));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("timeout",   32'(timeout),   32'(m_to));
    end

    // --------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        rd_byte_valid = 1'b0;
        flush = 1'b0;
        pop = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] n, input logic [7:0] a);
        cmd_start = 1'b1; cmd_num_regs = n; cmd_start_addr = a;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        rd_byte_valid = 1'b1; rd_byte = b;
        tick();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_seq [4];

        // Reset state
        #2;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_dout",  32'(dout),  32'd0);
        check("rst_flags", {28'd0, full, read_done, overflow, timeout}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Basic 4-byte read at 0x10
        cmd(8'd4, 8'h10);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        check("t1_done",  32'(read_done), 32'd1);
        check("t1_busy",  32'(busy),      32'd0);
        check("t1_level", 32'(level),     32'd4);
        exp_seq = '{ent(8'h10, 8'hA1), ent(8'h11, 8'hA2), ent(8'h12, 8'hA3), ent(8'h13, 8'hA4)};
        for (int i = 0; i < 4; i++) begin
            check("t1_dout", 32'(dout), 32'(exp_seq[i]));
            do_pop();
        end
        check("t1_empty", 32'(empty), 32'd1);
        do_pop();
        check("t1_hold",  32'(dout), 32'(ent(8'h13, 8'hA4)));

        // Zero-length command
        cmd(8'd0, 8'h33);
        check("t2_done",  32'(read_done), 32'd1);
        check("t2_busy",  32'(busy),      32'd0);
        send(8'h55);
        check("t2_empty", 32'(empty), 32'd1);

        // Overflow: 6 bytes into a 4-deep FIFO
        cmd(8'd6, 8'h20);
        for (int i = 0; i < 6; i++) send(8'hB0 + 8'(i));
        check("t3_level", 32'(level),     32'd4);
        check("t3_full",  32'(full),      32'd1);
        check("t3_ovf",   32'(overflow),  32'd1);
        check("t3_done",  32'(read_done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t3_dout", 32'(dout), 32'(ent(8'h20 + 8'(i), 8'hB0 + 8'(i))));
            do_pop();
        end
        flush = 1'b1; tick();
        check("t3_ovf_clr", 32'(overflow), 32'd0);

        // Address wrap
        cmd(8'd3, 8'hFE);
        send(8'h01); send(8'h02); send(8'h03);
        exp_seq = '{ent(8'hFE, 8'h01), ent(8'hFF, 8'h02), ent(8'h00, 8'h03), '0};
        for (int i = 0; i < 3; i++) begin
            check("t4_dout", 32'(dout), 32'(exp_seq[i]));
            do_pop();
        end

        // Timeout, with flush and cmd_start in the same cycle
        flush = 1'b1; cmd_start = 1'b1; cmd_num_regs = 8'd3; cmd_start_addr = 8'h50;
        tick();
        send(8'hC5);
        repeat (TMO - 1) tick();
        check("t5_to_early", 32'(timeout), 32'd0);
        check("t5_busy",     32'(busy),    32'd1);
        tick();
        check("t5_to",    32'(timeout),   32'd1);
        check("t5_busy2", 32'(busy),      32'd0);
        check("t5_level", 32'(level),     32'd1);
        check("t5_done",  32'(read_done), 32'd0);
        flush = 1'b1; tick();

        // Restart mid-collect; strobe during cmd_start ignored
        cmd(8'd5, 8'h40);
        send(8'h11); send(8'h22);
        cmd_start = 1'b1; cmd_num_regs = 8'd1; cmd_start_addr = 8'h80;
        rd_byte_valid = 1'b1; rd_byte = 8'hEE;
        tick();
        check("t6_busy", 32'(busy), 32'd1);
        send(8'h77);
        check("t6_level", 32'(level),     32'd3);
        check("t6_done",  32'(read_done), 32'd1);
        exp_seq = '{ent(8'h40, 8'h11), ent(8'h41, 8'h22), ent(8'h80, 8'h77), '0};
        for (int i = 0; i < 3; i++) begin
            check("t6_dout", 32'(dout), 32'(exp_seq[i]));
            do_pop();
        end

        // Push + pop while full
        cmd(8'd5, 8'h60);
        for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i));
        check("t7_full", 32'(full), 32'd1);
        rd_byte_valid = 1'b1; rd_byte = 8'hD4; pop = 1'b1;
        tick();
        check("t7_level", 32'(level),    32'd4);
        check("t7_ovf",   32'(overflow), 32'd0);
        check("t7_dout",  32'(dout),     32'(ent(8'h61, 8'hD1)));
        check("t7_done",  32'(read_done), 32'd1);
        flush = 1'b1; tick();

        // Flush drops a pushed byte that is still counted
        cmd(8'd2, 8'h70);
        flush = 1'b1; rd_byte_valid = 1'b1; rd_byte = 8'hE0; tick();
        check("t8_level", 32'(level), 32'd0);
        send(8'hE1);
        check("t8_done", 32'(read_done), 32'd1);
        check("t8_dout", 32'(dout), 32'(ent(8'h71, 8'hE1)));

        // Asynchronous reset mid-command
        cmd(8'd3, 8'h90);
        send(8'hF0);
        #2 rstn = 1'b0;
        #1;
        check("t9_level", 32'(level), 32'd0);
        check("t9_busy",  32'(busy),  32'd0);
        check("t9_dout",  32'(dout),  32'd0);
        check("t9_done",  32'(read_done), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
